// File: rtl/pic27ch_irq_dispatch_if.sv
// Handshake bundle between the 27-channel priority encoder, the dispatcher and the CPU.
// The master modport is the dispatcher's view. The slave modport is the view of the
// encoder and the CPU that drive it.
interface pic27ch_irq_dispatch_if;
    logic [2:0] pe_bus_act;
    logic [3:0] pe_chan;
    logic       irq_valid;
    logic [4:0] irq_vector;
    logic       irq_ready;
    logic       eoi;
    logic       in_service;
    logic       err_illegal;
    logic       err_timeout;

    modport master (
        input  pe_bus_act, pe_chan, irq_ready, eoi,
        output irq_valid, irq_vector, in_service, err_illegal, err_timeout
    );

    modport slave (
        output pe_bus_act, pe_chan, irq_ready, eoi,
        input  irq_valid, irq_vector, in_service, err_illegal, err_timeout
    );
endinterface

// File: rtl/pic27ch_irq_dispatch.sv
// Interrupt dispatcher behind the 27-channel priority encoder.
// It registers the encoder result and waits until the winner has been stable for
// SETTLE_CYCLES samples. It then offers vector 9*bus+chan to the CPU over valid/ready
// and holds off further dispatch until the CPU signals end-of-interrupt.
// Every output comes from a register, so there is no combinational path from input to output.
module pic27ch_irq_dispatch #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pic27ch_irq_dispatch_if.master bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_SERVICE = 2'd3;

    localparam int              TO_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [3:0]      SETTLE_N = 4'(SETTLE_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    logic [2:0]      s_bus;
    logic [3:0]      s_chan;
    logic [1:0]      state;
    logic [3:0]      stab_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [1:0]      l_bus;
    logic [3:0]      l_chan;

    logic            irq_valid_q;
    logic [4:0]      irq_vector_q;
    logic            in_service_q;
    logic            err_illegal_q;
    logic            err_timeout_q;

    logic [1:0]      w_bus;
    logic            req;
    logic            same;
    logic [3:0]      next_cnt;
    logic            settled;
    logic [4:0]      vec;

    assign bus.irq_valid   = irq_valid_q;
    assign bus.irq_vector  = irq_vector_q;
    assign bus.in_service  = in_service_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_timeout = err_timeout_q;

    // Single input stage that isolates the encoder's combinational outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_bus  <= 3'd0;
            s_chan <= 4'd0;
        end else begin
            s_bus  <= bus.pe_bus_act;
            s_chan <= bus.pe_chan;
        end
    end

    // Find the winner bus, count stability and decide whether this sample completes the settle window.
    // Bit 0 has the highest priority.
    always_comb begin
        w_bus = 2'd0;
        if (s_bus[0]) begin
            w_bus = 2'd0;
        end else if (s_bus[1]) begin
            w_bus = 2'd1;
        end else if (s_bus[2]) begin
            w_bus = 2'd2;
        end
        req      = (s_bus != 3'd0);
        same     = (w_bus == l_bus) && (s_chan == l_chan);
        next_cnt = (state == ST_SETTLE && same) ? stab_cnt + 4'd1 : 4'd1;
        settled  = req && (next_cnt == SETTLE_N);
        vec      = {w_bus, 3'b000} + 5'(w_bus) + 5'(s_chan);
    end

    // Dispatch FSM: settle, present, then service. The error flags are one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            stab_cnt      <= 4'd0;
            to_cnt        <= '0;
            l_bus         <= 2'd0;
            l_chan        <= 4'd0;
            irq_valid_q   <= 1'b0;
            irq_vector_q  <= 5'd0;
            in_service_q  <= 1'b0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state)
                ST_IDLE, ST_SETTLE: begin
                    if (!req) begin
                        state    <= ST_IDLE;
                        stab_cnt <= 4'd0;
                    end else if (settled) begin
                        stab_cnt <= 4'd0;
                        if (s_chan > 4'd8) begin
                            err_illegal_q <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            irq_vector_q <= vec;
                            irq_valid_q  <= 1'b1;
                            to_cnt       <= '0;
                            state        <= ST_PRESENT;
                        end
                    end else begin
                        state    <= ST_SETTLE;
                        stab_cnt <= next_cnt;
                        l_bus    <= w_bus;
                        l_chan   <= s_chan;
                    end
                end
                ST_PRESENT: begin
                    if (bus.irq_ready) begin
                        irq_valid_q  <= 1'b0;
                        in_service_q <= 1'b1;
                        state        <= ST_SERVICE;
                    end else if (to_cnt == TO_LAST) begin
                        irq_valid_q   <= 1'b0;
                        err_timeout_q <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (bus.eoi) begin
                        in_service_q <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pic27ch_irq_dispatch.sv
// Self-checking bench for pic27ch_irq_dispatch.
// Each stimulus episode works out from timing rules when every output event should
// happen and queues the expected event. A monitor running on the falling edge pops
// the queue and compares whenever the dispatcher shows an event.
module tb_pic27ch_irq_dispatch;
    localparam int SETTLE = 2;
    localparam int ACK    = 64;

    localparam int EV_DISP    = 0;
    localparam int EV_ILL     = 1;
    localparam int EV_TO      = 2;
    localparam int EV_SVC_ON  = 3;
    localparam int EV_SVC_OFF = 4;

    typedef struct {
        int         kind;
        logic [4:0] vec;
        int         when;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nbad = 0;
    ev_t  exp_q[$];

    pic27ch_irq_dispatch_if dif();

    pic27ch_irq_dispatch #(.SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(ACK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    // Free-running clock and a cycle stamp used to time expected events.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            EV_DISP:    return "dispatch";
            EV_ILL:     return "err_illegal";
            EV_TO:      return "err_timeout";
            EV_SVC_ON:  return "in_service_rise";
            default:    return "in_service_fall";
        endcase
    endfunction

    // Reference: the lowest set bus bit wins, and the vector is nine per bus plus the channel.
    function automatic logic [4:0] refVector(input logic [2:0] b, input logic [3:0] c);
        for (int i = 0; i < 3; i++) begin
            if (b[i]) return 5'(9 * i + int'(c));
        end
        return 5'd0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nvec++;
        if (actual != expected) begin
            nbad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushEv(input int kind, input logic [4:0] vec, input int when);
        ev_t e;
        e.kind = kind;
        e.vec  = vec;
        e.when = when;
        exp_q.push_back(e);
    endtask

    task automatic expectEvent(input int kind, input logic [4:0] vec);
        ev_t e;
        if (exp_q.size() == 0) begin
            nvec++;
            nbad++;
            $display("[TB] FAIL unexpected_%s: got event at cycle %0d, expected none", kname(kind), cyc);
        end else begin
            e = exp_q.pop_front();
            checkOutput("event_kind", kind, e.kind);
            checkOutput({kname(kind), "_cycle"}, cyc, e.when);
            if (kind == EV_DISP) checkOutput("irq_vector", int'(vec), int'(e.vec));
        end
    endtask

    // Monitor: turn output edges and pulses into events and check them against the queue.
    logic       prev_valid = 1'b0;
    logic       prev_svc = 1'b0;
    logic [4:0] held_vec = 5'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_svc   = 1'b0;
        end else begin
            if (dif.irq_valid && !prev_valid) expectEvent(EV_DISP, dif.irq_vector);
            else if (dif.irq_valid) checkOutput("vector_stable", int'(dif.irq_vector), int'(held_vec));
            if (dif.irq_valid) held_vec = dif.irq_vector;
            if (dif.in_service && !prev_svc) expectEvent(EV_SVC_ON, 5'd0);
            if (!dif.in_service && prev_svc) expectEvent(EV_SVC_OFF, 5'd0);
            if (dif.err_illegal) expectEvent(EV_ILL, 5'd0);
            if (dif.err_timeout) begin
                expectEvent(EV_TO, 5'd0);
                checkOutput("valid_low_at_timeout", int'(dif.irq_valid), 0);
            end
            prev_valid = dif.irq_valid;
            prev_svc   = dif.in_service;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setIn(input logic [2:0] b, input logic [3:0] c);
        dif.pe_bus_act = b;
        dif.pe_chan    = c;
    endtask

    // Idle gap with a stray eoi and ready, both of which the dispatcher must ignore.
    task automatic idleGap();
        setIn(3'd0, 4'd0);
        tick(1);
        dif.eoi = 1'b1;
        dif.irq_ready = 1'b1;
        tick(1);
        dif.eoi = 1'b0;
        dif.irq_ready = 1'b0;
        tick(3);
    endtask

    // One full dispatch episode.
    // The optional pre_c stage briefly shows a different channel, and the optional glitch drops the request for one cycle.
    // r is the ready delay, e is the eoi delay.
    // held keeps the request asserted through service so that it dispatches again.
    task automatic applyStimulus(input logic [2:0] b, input logic [3:0] c, input int pre_c,
                                 input bit glitch, input int r, input int e, input bit held);
        int         d;
        int         f;
        logic [4:0] v;
        bit         keep;
        v    = refVector(b, c);
        keep = held && (r < ACK);
        if (pre_c >= 0) begin
            setIn(b, 4'(pre_c));
            tick(1);
        end
        if (glitch) begin
            setIn(b, c);
            tick(1);
            setIn(3'd0, 4'd0);
            tick(1);
        end
        setIn(b, c);
        d = cyc + 1 + SETTLE;
        pushEv(EV_DISP, v, d);
        tick(1 + SETTLE);
        if (!keep) setIn(3'd0, 4'd0);
        if (r < ACK) begin
            tick(r);
            dif.irq_ready = 1'b1;
            pushEv(EV_SVC_ON, 5'd0, cyc + 1);
            tick(1);
            dif.irq_ready = 1'b0;
            tick(e);
            dif.eoi = 1'b1;
            f = cyc + 1;
            pushEv(EV_SVC_OFF, 5'd0, f);
            tick(1);
            dif.eoi = 1'b0;
            if (keep) begin
                pushEv(EV_DISP, v, f + SETTLE);
                tick(SETTLE);
                setIn(3'd0, 4'd0);
                dif.irq_ready = 1'b1;
                pushEv(EV_SVC_ON, 5'd0, cyc + 1);
                tick(1);
                dif.irq_ready = 1'b0;
                dif.eoi = 1'b1;
                pushEv(EV_SVC_OFF, 5'd0, cyc + 1);
                tick(1);
                dif.eoi = 1'b0;
            end
        end else begin
            pushEv(EV_TO, 5'd0, d + ACK);
            tick(ACK);
        end
        idleGap();
    endtask

    // Illegal channel held for exactly the settle window, which gives a single error pulse.
    task automatic applyIllegal(input logic [2:0] b, input logic [3:0] c);
        setIn(b, c);
        pushEv(EV_ILL, 5'd0, cyc + 1 + SETTLE);
        tick(SETTLE);
        idleGap();
    endtask

    // A request visible for one sample only must not dispatch.
    task automatic applyBlip(input logic [2:0] b, input logic [3:0] c);
        setIn(b, c);
        tick(1);
        idleGap();
    endtask

    // Reset asserted while a vector is being presented.
    task automatic applyResetMidPresent(input logic [2:0] b, input logic [3:0] c);
        setIn(b, c);
        pushEv(EV_DISP, refVector(b, c), cyc + 1 + SETTLE);
        tick(1 + SETTLE + 2);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_irq_valid", int'(dif.irq_valid), 0);
        checkOutput("rst_in_service", int'(dif.in_service), 0);
        checkOutput("rst_err_illegal", int'(dif.err_illegal), 0);
        checkOutput("rst_err_timeout", int'(dif.err_timeout), 0);
        setIn(3'd0, 4'd0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        checkOutput("post_rst_irq_valid", int'(dif.irq_valid), 0);
        checkOutput("post_rst_in_service", int'(dif.in_service), 0);
        idleGap();
    endtask

    // Watchdog so the run always ends, even if the design stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: directed scenarios first, then randomized episodes.
    initial begin
        logic [2:0] b;
        logic [3:0] c;
        int         pc;
        int         r;
        int         sel;
        setIn(3'd0, 4'd0);
        dif.irq_ready = 1'b0;
        dif.eoi       = 1'b0;
        rst_n         = 1'b0;
        tick(3);
        checkOutput("reset_irq_valid", int'(dif.irq_valid), 0);
        checkOutput("reset_irq_vector", int'(dif.irq_vector), 0);
        checkOutput("reset_in_service", int'(dif.in_service), 0);
        checkOutput("reset_err_illegal", int'(dif.err_illegal), 0);
        checkOutput("reset_err_timeout", int'(dif.err_timeout), 0);
        rst_n = 1'b1;
        tick(3);

        $display("[TB] directed scenarios");
        applyStimulus(3'b010, 4'd4, -1, 1'b0, 1, 2, 1'b0);
        applyStimulus(3'b110, 4'd8, -1, 1'b0, 0, 0, 1'b0);
        applyStimulus(3'b100, 4'd8, -1, 1'b0, 3, 1, 1'b0);
        applyStimulus(3'b011, 4'd5, 3, 1'b0, 2, 0, 1'b0);
        applyStimulus(3'b001, 4'd6, -1, 1'b1, 0, 1, 1'b0);
        applyBlip(3'b101, 4'd2);
        applyIllegal(3'b001, 4'd11);
        applyStimulus(3'b100, 4'd1, -1, 1'b0, ACK, 0, 1'b0);
        applyStimulus(3'b010, 4'd7, -1, 1'b0, ACK - 1, 0, 1'b0);
        applyStimulus(3'b001, 4'd0, -1, 1'b0, 2, 3, 1'b1);
        applyResetMidPresent(3'b010, 4'd3);

        $display("[TB] randomized episodes");
        for (int k = 0; k < 30; k++) begin
            sel = int'($urandom_range(0, 9));
            b   = 3'($urandom_range(1, 7));
            c   = 4'($urandom_range(0, 8));
            if (sel == 0) begin
                applyIllegal(b, 4'($urandom_range(9, 15)));
            end else if (sel == 1) begin
                applyBlip(b, c);
            end else begin
                pc = ($urandom_range(0, 2) == 0) ? (int'(c) + int'($urandom_range(1, 8))) % 9 : -1;
                if ($urandom_range(0, 3) == 0) r = ACK - 2 + int'($urandom_range(0, 3));
                else r = int'($urandom_range(0, 5));
                applyStimulus(b, c, pc, $urandom_range(0, 3) == 0, r, int'($urandom_range(0, 4)),
                              $urandom_range(0, 3) == 0);
            end
        end

        tick(10);
        checkOutput("events_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
